spi_slave_sync: RTL and testbench

- SPI mode-0 (CPOL=0, CPHA=0) target, fully synchronous to the system clock; the responder end for spi_master.
- Oversamples sclk/cs_n/mosi through synchronizers. Exchanges 8-bit MSB-first bytes.
- Exposes a byte-level rx valid/ready interface and a tx load acknowledge to local logic.
- Drives a shared miso line through an output-enable, so several instances can sit on one bus.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_sync.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 target.
// Word size default, FSM state type and SPI mode constants.
package spi_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input.
// An extra flop behind the last stage yields rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_din};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 target oversampled on the system clock.
// SPI_SLAVE_SYNC_OVERRUN_EN enables the sticky overrun flag.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_mosi_s;
    logic w_sample, w_shift;
    logic w_byte_done;
    logic w_unused_sync;

    logic [SYNC_STAGES-1:0] r_mosi_sync;

    spi_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nx;
    logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nx;
    logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nx;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nx;
    logic              r_rx_valid, w_rx_valid_nx;
    logic              r_tx_ack, w_tx_ack_nx;
    logic              r_miso_oe, w_miso_oe_nx;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (CPOL)
    ) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .i_din  (sclk),
        .o_sync (w_sclk_s),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .reset  (reset),
        .i_din  (cs_n),
        .o_sync (w_cs_s),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    assign w_unused_sync = w_sclk_s ^ w_cs_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Mode 0: sample on the leading (rising) edge, shift on the trailing one.
    assign w_sample = (CPHA == 1'b0) ? w_sclk_rise : w_sclk_fall;
    assign w_shift  = (CPHA == 1'b0) ? w_sclk_fall : w_sclk_rise;

    assign w_byte_done = (r_state == ACTIVE) & ~w_cs_rise
                       & w_sample & (r_bit_cnt == LAST);

    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_rx_shift_nx = r_rx_shift;
        w_tx_shift_nx = r_tx_shift;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = r_rx_valid & ~rx_ready;
        w_tx_ack_nx   = 1'b0;
        w_miso_oe_nx  = r_miso_oe;

        unique case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nx    = ACTIVE;
                    w_tx_shift_nx = tx_data;
                    w_tx_ack_nx   = 1'b1;
                    w_bit_cnt_nx  = '0;
                    w_miso_oe_nx  = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nx    = IDLE;
                    w_bit_cnt_nx  = '0;
                    w_rx_shift_nx = '0;
                    w_miso_oe_nx  = 1'b0;
                end else if (w_sample) begin
                    w_rx_shift_nx = {r_rx_shift[DATA_W-2:0], w_mosi_s};
                    if (r_bit_cnt == LAST) begin
                        w_rx_data_nx  = w_rx_shift_nx;
                        w_rx_valid_nx = 1'b1;
                        w_bit_cnt_nx  = '0;
                    end else begin
                        w_bit_cnt_nx  = r_bit_cnt + 1'b1;
                    end
                end else if (w_shift) begin
                    // Count of zero here means a byte just finished.
                    if (r_bit_cnt != '0) begin
                        w_tx_shift_nx = {r_tx_shift[DATA_W-2:0], 1'b0};
                    end else begin
                        w_tx_shift_nx = tx_data;
                        w_tx_ack_nx   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_miso_oe  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_tx_ack   <= w_tx_ack_nx;
            r_miso_oe  <= w_miso_oe_nx;
        end
    end

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_byte_done && r_rx_valid && !rx_ready) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`else
    logic w_unused_done;

    assign w_unused_done = w_byte_done;
    assign overrun       = 1'b0;
`endif

    assign miso     = r_miso_oe & r_tx_shift[DATA_W-1];
    assign miso_oe  = r_miso_oe;
    assign tx_ack   = r_tx_ack;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboard bench for spi_slave_sync with a mode-0 master model.
// Honours SPI_SLAVE_SYNC_OVERRUN_EN for the overrun expectation.
module tb_spi_slave_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;

    int n_chk   = 0;
    int n_err   = 0;
    int ack_cnt = 0;
    bit sb_en   = 1'b1;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

`ifdef SPI_SLAVE_SYNC_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    spi_slave_sync #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_ack === 1'b1) ack_cnt++;
        if (sb_en && !reset && rx_valid === 1'b1 && rx_ready) begin
            if (exp_rx.size() == 0) check("rx_spurious", rx_data, 32'hFFFF);
            else check("rx_data", rx_data, exp_rx.pop_front());
        end
    end

    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
    endtask

    task automatic cs_high();
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // One byte, sclk period 8 clk; hold leaves sclk high at the end.
    task automatic spi_byte(input logic [7:0] mo, input int nbits,
                            input bit hold, input logic [7:0] nxt,
                            output logic [7:0] mi);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (4) @(negedge clk);
            acc[7-i] = miso;
            sclk = 1'b1;
            if (i == 0) tx_data = nxt;
            repeat (4) @(negedge clk);
            if (!(hold && i == nbits - 1)) sclk = 1'b0;
        end
        mi = acc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        int         a0;

        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sclk     = 1'($urandom);
            cs_n     = 1'($urandom);
            mosi     = 1'($urandom);
            tx_data  = 8'($urandom);
            rx_ready = 1'($urandom);
        end
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_tx_ack", tx_ack, 0);
        @(negedge clk);
        sclk     = 1'b0;
        cs_n     = 1'b1;
        mosi     = 1'b0;
        rx_ready = 1'b1;
        reset    = 1'b0;
        repeat (4) @(negedge clk);

        a0      = ack_cnt;
        tx_data = 8'hB1;
        exp_tx.push_back(8'hB1);
        exp_rx.push_back(8'hA2);
        cs_low();
        spi_byte(8'hA2, 8, 1'b1, 8'hB1, mi);
        cs_high();
        check("t2_miso", mi, exp_tx.pop_front());
        check("t2_rx_hold", rx_data, 8'hA2);
        check("t2_acks", ack_cnt - a0, 1);
        check("t2_pending", exp_rx.size(), 0);

        a0      = ack_cnt;
        tx_data = 8'h3C;
        exp_tx.push_back(8'h3C);
        exp_tx.push_back(8'h5A);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        cs_low();
        spi_byte(8'h11, 8, 1'b0, 8'h5A, mi);
        check("t3_miso0", mi, exp_tx.pop_front());
        spi_byte(8'h22, 8, 1'b1, 8'h5A, mi);
        cs_high();
        check("t3_miso1", mi, exp_tx.pop_front());
        check("t3_acks", ack_cnt - a0, 2);
        check("t3_pending", exp_rx.size(), 0);

        tx_data = 8'h00;
        cs_low();
        spi_byte(8'hF0, 4, 1'b1, 8'h00, mi);
        cs_high();
        check("t4_oe_idle", miso_oe, 0);
        check("t4_miso_idle", miso, 0);
        check("t4_rx_valid", rx_valid, 0);
        tx_data = 8'h81;
        exp_tx.push_back(8'h81);
        exp_rx.push_back(8'h7E);
        cs_low();
        spi_byte(8'h7E, 8, 1'b1, 8'h81, mi);
        cs_high();
        check("t4_miso", mi, exp_tx.pop_front());
        check("t4_pending", exp_rx.size(), 0);

        sb_en    = 1'b0;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        cs_low();
        spi_byte(8'h55, 8, 1'b0, 8'h00, mi);
        spi_byte(8'hAA, 8, 1'b1, 8'h00, mi);
        cs_high();
        check("t5_rx_data", rx_data, 8'hAA);
        check("t5_rx_valid", rx_valid, 1);
        check("t5_overrun", overrun, EXP_OVR);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_rx_clear", rx_valid, 0);
        check("t5_ovr_sticky", overrun, EXP_OVR);
        sb_en = 1'b1;

        cs_low();
        spi_byte(8'hC3, 5, 1'b1, 8'h00, mi);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_oe", miso_oe, 0);
        check("t6_rst_ovr", overrun, 0);
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_idle_valid", rx_valid, 0);
        tx_data = 8'h6B;
        exp_tx.push_back(8'h6B);
        exp_rx.push_back(8'h96);
        cs_low();
        spi_byte(8'h96, 8, 1'b1, 8'h6B, mi);
        cs_high();
        check("t6_miso", mi, exp_tx.pop_front());
        check("t6_rx_data", rx_data, 8'h96);
        check("t6_pending", exp_rx.size(), 0);
        check("t6_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
